// File: rtl/iob_ram_tdp_be_init.sv
// True dual-port RAM with per-byte write enables and a built-in clear engine.
// After reset, or on request, every word is filled with INIT_VAL before user access is allowed.
module iob_ram_tdp_be_init #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 4,
    parameter int unsigned       READ_LAT   = 1,
    parameter int unsigned       WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                init_i,
    output logic                busy_o,
    input  logic                enA_i,
    input  logic [DATA_W/8-1:0] weA_i,
    input  logic [ADDR_W-1:0]   addrA_i,
    input  logic [DATA_W-1:0]   dA_i,
    output logic [DATA_W-1:0]   dA_o,
    output logic                rvalidA_o,
    input  logic                enB_i,
    input  logic [DATA_W/8-1:0] weB_i,
    input  logic [ADDR_W-1:0]   addrB_i,
    input  logic [DATA_W-1:0]   dB_i,
    output logic [DATA_W-1:0]   dB_o,
    output logic                rvalidB_o,
    output logic                collision_o
);

    localparam int unsigned NB = DATA_W / 8;

    typedef enum logic {StClear, StReady} state_e;

    state_e                    r_state, w_state_d;
    logic [ADDR_W:0]           r_clr_cnt, w_clr_cnt_d, w_clr_inc;
    logic [DATA_W-1:0]         r_mem [2**ADDR_W];

    logic                      w_busy, w_coll;
    logic [1:0]                w_acc, w_is_wr, w_rd_fire;
    logic [1:0][NB-1:0]        w_we;
    logic [1:0][ADDR_W-1:0]    w_addr;
    logic [1:0][DATA_W-1:0]    w_wdat, w_old, w_rd_dat;

    logic [1:0]                r_s1_vld;
    logic [1:0][DATA_W-1:0]    r_s1_dat;
    logic                      r_coll;
    logic [1:0]                w_vout;
    logic [1:0][DATA_W-1:0]    w_dout;

    // Clear engine and state

    assign w_clr_inc = r_clr_cnt + (ADDR_W+1)'(1);

    always_comb begin
        w_state_d   = r_state;
        w_clr_cnt_d = r_clr_cnt;
        unique case (r_state)
            StClear: begin
                w_clr_cnt_d = w_clr_inc;
                // Top counter bit set means the last word has just been written.
                if (w_clr_inc[ADDR_W]) begin
                    w_state_d   = StReady;
                    w_clr_cnt_d = '0;
                end
            end
            StReady: begin
                if (init_i) begin
                    w_state_d   = StClear;
                    w_clr_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= StClear;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_clr_cnt <= w_clr_cnt_d;
        end
    end

    assign w_busy = (r_state == StClear);
    assign busy_o = w_busy;

    // Port access

    assign w_acc  = {enB_i, enA_i} & {2{~w_busy}};
    assign w_we   = {weB_i, weA_i};
    assign w_addr = {addrB_i, addrA_i};
    assign w_wdat = {dB_i, dA_i};

    always_comb begin
        w_old     = '0;
        w_rd_dat  = '0;
        w_is_wr   = '0;
        w_rd_fire = '0;
        for (int p = 0; p < 2; p++) begin
            w_old[p]     = r_mem[w_addr[p]];
            w_is_wr[p]   = |w_we[p];
            w_rd_fire[p] = w_acc[p] && !(w_is_wr[p] && (WRITE_MODE == 2));
            w_rd_dat[p]  = w_old[p];
            if (WRITE_MODE == 1) begin
                for (int k = 0; k < NB; k++) begin
                    if (w_we[p][k]) w_rd_dat[p][8*k +: 8] = w_wdat[p][8*k +: 8];
                end
            end
        end
    end

    assign w_coll = (&w_acc) && (w_addr[0] == w_addr[1]) && (|w_is_wr);

    // Port B writes are issued last so it wins overlapping bytes.
    always_ff @(posedge clk_i) begin
        if (w_busy) begin
            r_mem[r_clr_cnt[ADDR_W-1:0]] <= INIT_VAL;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < NB; k++) begin
                    if (w_acc[p] && w_we[p][k]) begin
                        r_mem[w_addr[p]][8*k +: 8] <= w_wdat[p][8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_s1_vld <= '0;
            r_s1_dat <= '0;
            r_coll   <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_fire;
            r_coll   <= w_coll;
            for (int p = 0; p < 2; p++) begin
                if (w_rd_fire[p]) r_s1_dat[p] <= w_rd_dat[p];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [1:0]             r_s2_vld;
        logic [1:0][DATA_W-1:0] r_s2_dat;

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                r_s2_vld <= '0;
                r_s2_dat <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                for (int p = 0; p < 2; p++) begin
                    if (r_s1_vld[p]) r_s2_dat[p] <= r_s1_dat[p];
                end
            end
        end

        assign w_vout = r_s2_vld;
        assign w_dout = r_s2_dat;
    end else begin : g_lat1
        assign w_vout = r_s1_vld;
        assign w_dout = r_s1_dat;
    end

    assign dA_o        = w_dout[0];
    assign dB_o        = w_dout[1];
    assign rvalidA_o   = w_vout[0];
    assign rvalidB_o   = w_vout[1];
    assign collision_o = r_coll;

endmodule

// File: doc/iob_ram_tdp_be_init.md
IOB_RAM_TDP_BE_INIT -- requirements
Module: iob_ram_tdp_be_init

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 32, word width; SHALL be a multiple of 8.
- ADDR_W, 4, address width; depth is 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- WRITE_MODE, 0, port output on write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear engine.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all logic on rising edge.
- arst_n_i, in, 1, reset; asynchronous and active-low.
- init_i, in, 1, request a memory clear; honoured only in READY.
- busy_o, out, 1, high while the clear engine runs.
- enA_i / enB_i, in, 1, port access enable.
- weA_i / weB_i, in, DATA_W/8, byte write enables; all-zero means read.
- addrA_i / addrB_i, in, ADDR_W, word address.
- dA_i / dB_i, in, DATA_W, write data.
- dA_o / dB_o, out, DATA_W, read data.
- rvalidA_o / rvalidB_o, out, 1, one-cycle pulse aligned with new dX_o.
- collision_o, out, 1, one-cycle pulse flagging a same-address conflict.

Function
REQ-003 The FSM SHALL have two states, CLEAR and READY; reset SHALL enter CLEAR with the clear address counter at 0.
REQ-004 In CLEAR, the block SHALL write INIT_VAL to the word at the counter address each cycle, incrementing the counter by one, and SHALL enter READY on the cycle after writing address 2**ADDR_W-1 (2**ADDR_W cycles in CLEAR).
REQ-005 busy_o SHALL equal 1 exactly while in CLEAR.
REQ-006 In READY, init_i=1 SHALL move the FSM to CLEAR with the counter at 0 on the next edge.
REQ-007 init_i SHALL be ignored in CLEAR.
REQ-008 While busy_o=1, enA_i and enB_i SHALL be masked: no user writes, no rvalid pulses, dX_o held.
REQ-009 An access is accepted when enX_i=1 and busy_o=0; for each byte k with weX_i[k]=1, byte k of the addressed word SHALL be updated at that edge.
REQ-010 For an accepted read, dX_o SHALL present the addressed word READ_LAT cycles after the accepting edge, and rvalidX_o SHALL pulse in the same cycle.
REQ-011 For an accepted write, dX_o SHALL follow WRITE_MODE:
- READ_FIRST: old word.
- WRITE_FIRST: merged word (enabled bytes new, others old).
- NO_CHANGE: dX_o held and no rvalidX_o pulse.
- In the first two modes, rvalidX_o SHALL pulse with the READ_LAT timing of REQ-010.
REQ-012 With READ_LAT=2, an extra output register stage SHALL be inserted; back-to-back accesses SHALL be fully pipelined at one per cycle per port.
REQ-013 dX_o SHALL hold its last value whenever no new data is due.
REQ-014 Collision conditions and resolution:
- Collision: both ports accepted, same address, at least one writing.
- collision_o SHALL pulse 1 cycle after that edge.
- Overlapping write bytes: port B SHALL win.
- A read on one port during a write by the other to the same address SHALL return the pre-write word.
REQ-015 Address arithmetic SHALL be modulo 2**ADDR_W; the clear counter SHALL be ADDR_W+1 bits so the terminal count is detected without wrap ambiguity.

Reset
REQ-016 Asserting arst_n_i=0 SHALL immediately force the following outputs:
- dA_o, dB_o: 0.
- rvalidA_o, rvalidB_o, collision_o: 0.
- busy_o: 1.
- FSM: CLEAR, counter 0.
REQ-017 Memory array contents SHALL NOT be reset directly; they are cleared only by the clear engine after reset deassertion.
REQ-018 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-019 Reset asserted mid-pipeline SHALL discard in-flight reads, with no rvalid pulse after release.

Verification
REQ-020 Reset release, defaults, INIT_VAL=0 -> busy_o=1 for exactly 16 cycles; afterwards port A reads of addresses 0..15 all return 0 with rvalidA_o after READ_LAT.
REQ-021 Port A writes addr i data 32+i with weA=4'hF; port B reads 0..15 -> dB_o=32+i each with rvalidB_o; repeat with READ_LAT=2 -> same data one cycle later, back-to-back.
REQ-022 Byte enables: word 3 = 0x11223344, then write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD.
REQ-023 Same-cycle A write 0x000000AA / B write 0x000000BB to addr 5 -> collision_o pulses one cycle later; addr 5 reads 0x000000BB.
REQ-024 WRITE_MODE sweep, write 0x55 over 0x22 at addr 7:
- READ_FIRST: dA_o=0x22 with rvalid.
- WRITE_FIRST: dA_o=0x55 with rvalid.
- NO_CHANGE: dA_o unchanged, no rvalid.
REQ-025 init_i in READY with data loaded -> busy_o high 16 cycles, accesses masked (no rvalid); afterwards all words read INIT_VAL; reset at clear cycle 8 -> clear restarts, 16 more busy cycles.
